// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: sole writer of the register file write port, merging ALU results with FIFO-buffered loads.
// Optional build macro WB_FWD_EN adds rs1_fwd_data/rs2_fwd_data forwarding outputs.
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [REG_W-1:0]  alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [REG_W-1:0]  ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [REG_W-1:0]  q_rs1,
   input  logic [REG_W-1:0]  q_rs2,
`ifdef WB_FWD_EN
   output logic [DATA_W-1:0] rs1_fwd_data,
   output logic [DATA_W-1:0] rs2_fwd_data,
`endif
   output logic              rs1_busy,
   output logic              rs2_busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [DEPTH-1:0]  live_reg, live_next;
   logic [REG_W-1:0]  rd_reg   [DEPTH];
   logic [DATA_W-1:0] data_reg [DEPTH];
   logic [PTR_W-1:0]  head_reg, tail_reg;
   logic [CNT_W-1:0]  count_reg, count_next;

   logic              rf_we_reg;
   logic [REG_W-1:0]  rf_waddr_reg;
   logic [DATA_W-1:0] rf_wdata_reg;

   logic alu_wr, push, pop;
   logic [DEPTH-1:0] ld_hit, alu_hit, rs1_hit, rs2_hit;

   assign ld_ready = (count_reg != FULL);
   assign alu_wr   = alu_valid && (alu_rd != '0);
   // Loads to x0 are handshaked but dropped on the floor.
   assign push     = ld_valid && ld_ready && (ld_rd != '0);
   assign pop      = !alu_wr && (count_reg != '0);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign ld_hit[gi]  = (rd_reg[gi] == ld_rd);
         assign alu_hit[gi] = (rd_reg[gi] == alu_rd);
         assign rs1_hit[gi] = live_reg[gi] && (rd_reg[gi] == q_rs1);
         assign rs2_hit[gi] = live_reg[gi] && (rd_reg[gi] == q_rs2);
      end
   endgenerate

   // A load enqueued alongside an ALU write to the same rd is older, so it enters dead.
   always_comb begin
      live_next = live_reg;
      for (int i = 0; i < DEPTH; i++) begin
         if (push && ld_hit[i])
            live_next[i] = 1'b0;
         if (alu_wr && alu_hit[i])
            live_next[i] = 1'b0;
         if (pop && (head_reg == PTR_W'(i)))
            live_next[i] = 1'b0;
         if (push && (tail_reg == PTR_W'(i)))
            live_next[i] = !(alu_wr && (alu_rd == ld_rd));
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_reg     <= '0;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= '0;
         rf_wdata_reg <= '0;
      end else begin
         live_reg  <= live_next;
         count_reg <= count_next;
         if (push)
            tail_reg <= tail_reg + 1'b1;
         if (pop)
            head_reg <= head_reg + 1'b1;
         if (alu_wr) begin
            rf_we_reg    <= 1'b1;
            rf_waddr_reg <= alu_rd;
            rf_wdata_reg <= alu_data;
         end else if (count_reg != '0) begin
            rf_we_reg    <= live_reg[head_reg];
            rf_waddr_reg <= rd_reg[head_reg];
            rf_wdata_reg <= data_reg[head_reg];
         end else begin
            rf_we_reg    <= 1'b0;
         end
      end
   end

   // Payload storage carries no reset; validity is tracked solely by live_reg.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_reg[tail_reg]   <= ld_rd;
         data_reg[tail_reg] <= ld_data;
      end
   end

   assign rf_we    = rf_we_reg;
   assign rf_waddr = rf_waddr_reg;
   assign rf_wdata = rf_wdata_reg;

   assign rs1_busy = (|rs1_hit) && (q_rs1 != '0);
   assign rs2_busy = (|rs2_hit) && (q_rs2 != '0);

`ifdef WB_FWD_EN
   // At most one live entry per rd, so OR-combining the matches is a clean select.
   always_comb begin
      rs1_fwd_data = '0;
      rs2_fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rs1_hit[i] && (q_rs1 != '0))
            rs1_fwd_data = rs1_fwd_data | data_reg[i];
         if (rs2_hit[i] && (q_rs2 != '0))
            rs2_fwd_data = rs2_fwd_data | data_reg[i];
      end
   end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; one line per checked transaction, summary at the end.
module tb_rf_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
`ifdef WB_FWD_EN
   logic [31:0] rs1_fwd_data;
   logic [31:0] rs2_fwd_data;
`endif

   int checks = 0;
   int errors = 0;

   rf_wb_arbiter #(.DATA_W(32), .REG_W(5), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_rd        (ld_rd),
      .ld_data      (ld_data),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .q_rs1        (q_rs1),
      .q_rs2        (q_rs2),
`ifdef WB_FWD_EN
      .rs1_fwd_data (rs1_fwd_data),
      .rs2_fwd_data (rs2_fwd_data),
`endif
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      ld_valid  = 1'b0;
      ld_rd     = '0;
      ld_data   = '0;
      q_rs1     = '0;
      q_rs2     = '0;

      // Reset state
      tick();
      tick();
      check("rst_we",    32'(rf_we), 0);
      check("rst_waddr", 32'(rf_waddr), 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_ready", 32'(ld_ready), 1);
      check("rst_busy1", 32'(rs1_busy), 0);
      reset = 1'b0;

      // ALU path: one-cycle latency; rd 0 is ignored and waddr/wdata hold
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      check("alu_we",    32'(rf_we), 1);
      check("alu_waddr", 32'(rf_waddr), 5);
      check("alu_wdata", rf_wdata, 32'hDEADBEEF);
      alu_rd = 5'd0; alu_data = 32'h0000_0123;
      tick();
      check("alu_x0_we",    32'(rf_we), 0);
      check("alu_x0_waddr", 32'(rf_waddr), 5);
      check("alu_x0_wdata", rf_wdata, 32'hDEADBEEF);
      alu_valid = 1'b0;

      // Load to x0 is consumed without a write
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
      tick();
      ld_valid = 1'b0;
      tick();
      check("ld_x0_we",    32'(rf_we), 0);
      check("ld_x0_ready", 32'(ld_ready), 1);

      // ALU stream starves the FIFO; ready drops after 4 accepts
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_0A10;
      q_rs1 = 5'd3; q_rs2 = 5'd10;
      for (int k = 1; k <= 4; k++) begin
         ld_valid = 1'b1; ld_rd = 5'(k); ld_data = 32'h100 + 32'(k);
         tick();
         check("fill_we",    32'(rf_we), 1);
         check("fill_ready", 32'(ld_ready), (k < 4) ? 32'd1 : 32'd0);
      end
      ld_rd = 5'd5; ld_data = 32'h105;
      tick();
      check("full_ready", 32'(ld_ready), 0);
      check("full_waddr", 32'(rf_waddr), 10);
      check("full_busy1", 32'(rs1_busy), 1);
      check("full_busy2", 32'(rs2_busy), 0);
      alu_valid = 1'b0;
      tick();
      check("drain1_we",    32'(rf_we), 1);
      check("drain1_waddr", 32'(rf_waddr), 1);
      check("drain1_wdata", rf_wdata, 32'h101);
      check("drain1_ready", 32'(ld_ready), 1);
      tick();
      check("drain2_waddr", 32'(rf_waddr), 2);
      ld_valid = 1'b0;
      for (int k = 3; k <= 5; k++) begin
         tick();
         check("drain_we",    32'(rf_we), 1);
         check("drain_waddr", 32'(rf_waddr), 32'(k));
         check("drain_wdata", rf_wdata, 32'h100 + 32'(k));
      end
      tick();
      check("drained_we",    32'(rf_we), 0);
      check("drained_busy1", 32'(rs1_busy), 0);

      // Queued load killed by a later ALU write to the same rd
      q_rs1 = 5'd7; q_rs2 = 5'd0;
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
      tick();
      ld_valid = 1'b0;
      check("kill_busy_before", 32'(rs1_busy), 1);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h22;
      tick();
      alu_valid = 1'b0;
      check("kill_alu_we",    32'(rf_we), 1);
      check("kill_alu_waddr", 32'(rf_waddr), 7);
      check("kill_alu_wdata", rf_wdata, 32'h22);
      check("kill_busy_after", 32'(rs1_busy), 0);
      tick();
      check("kill_slot_we", 32'(rf_we), 0);

      // Same-cycle load and ALU to one rd: the load is older and dies
      q_rs1 = 5'd8;
      ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h8888;
      alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h9999;
      tick();
      ld_valid = 1'b0; alu_valid = 1'b0;
      check("same_we",    32'(rf_we), 1);
      check("same_wdata", rf_wdata, 32'h9999);
      check("same_busy",  32'(rs1_busy), 0);
      tick();
      check("same_slot_we", 32'(rf_we), 0);

      // Two loads to rd 3: younger wins
      q_rs1 = 5'd3;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hA;
      tick();
      ld_data = 32'hB;
      tick();
      ld_valid = 1'b0;
      check("waw_busy", 32'(rs1_busy), 1);
`ifdef WB_FWD_EN
      check("waw_fwd", rs1_fwd_data, 32'hB);
`endif
      alu_valid = 1'b0;
      tick();
      check("waw_old_we", 32'(rf_we), 0);
      check("waw_busy_mid", 32'(rs1_busy), 1);
      tick();
      check("waw_new_we",    32'(rf_we), 1);
      check("waw_new_waddr", 32'(rf_waddr), 3);
      check("waw_new_wdata", rf_wdata, 32'hB);
      check("waw_busy_end",  32'(rs1_busy), 0);

      // Asynchronous reset with three loads queued
      q_rs1 = 5'd2;
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
      for (int k = 1; k <= 3; k++) begin
         ld_valid = 1'b1; ld_rd = 5'(k); ld_data = 32'h200 + 32'(k);
         tick();
      end
      ld_valid = 1'b0;
      check("pre_rst_busy", 32'(rs1_busy), 1);
      check("pre_rst_we",   32'(rf_we), 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_we",    32'(rf_we), 0);
      check("async_rst_ready", 32'(ld_ready), 1);
      check("async_rst_busy",  32'(rs1_busy), 0);
      alu_valid = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_rst_we", 32'(rf_we), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
